reg_write_arbiter: RTL

//   Shares the single write port of the 8x8 register file between two writeback sources:
//   A = ALU result, B = data-memory load.

---
 rtl/reg_write_arbiter_if.sv | 33 +++
 rtl/reg_write_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/reg_write_arbiter_if.sv
// Writeback port bundle between the two write sources (ALU, load unit),
// the pipeline control signals and the register-file write port.
interface reg_write_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                         A_VALID;
    logic [ADDR_WIDTH-1:0]        A_ADDR;
    logic [DATA_WIDTH-1:0]        A_DATA;
    logic                         A_READY;
    logic                         B_VALID;
    logic [ADDR_WIDTH-1:0]        B_ADDR;
    logic [DATA_WIDTH-1:0]        B_DATA;
    logic                         B_READY;
    logic                         STALL;
    logic                         FLUSH;
    logic                         WR_EN;
    logic [ADDR_WIDTH-1:0]        WR_ADDR;
    logic [DATA_WIDTH-1:0]        WR_DATA;
    logic [(2**ADDR_WIDTH)-1:0]   PENDING;

    // Sources and pipeline control side
    modport master (
        output A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, STALL, FLUSH,
        input  A_READY, B_READY, WR_EN, WR_ADDR, WR_DATA, PENDING
    );

    // Arbiter side
    modport slave (
        input  A_VALID, A_ADDR, A_DATA, B_VALID, B_ADDR, B_DATA, STALL, FLUSH,
        output A_READY, B_READY, WR_EN, WR_ADDR, WR_DATA, PENDING
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the single register-file write port between the ALU (A) and the
// load unit (B). One write is accepted per cycle into a one-entry commit
// stage, which drains to the register file on every non-stalled cycle.
module reg_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic                CLK,
    input logic                RESET_N,
    reg_write_arbiter_if.slave bus
);
    localparam int MASK_WIDTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    logic                  stage_valid_r;
    logic [ADDR_WIDTH-1:0] stage_addr_r;
    logic [DATA_WIDTH-1:0] stage_data_r;
    src_e                  last_grant_r;

    logic                  space_s;
    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  accept_a_s;
    logic                  accept_b_s;
    logic [MASK_WIDTH-1:0] pending_s;

    // The stage can take a new write when it is empty or draining this cycle.
    assign space_s = ~stage_valid_r | ~bus.STALL;

    // Pick one requester; round-robin alternates against the last winner.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        case ({bus.A_VALID, bus.B_VALID})
            2'b10: grant_a_s = 1'b1;
            2'b01: grant_b_s = 1'b1;
            2'b11: begin
                if (FIXED_PRIO || (last_grant_r == SRC_B)) begin
                    grant_a_s = 1'b1;
                end else begin
                    grant_b_s = 1'b1;
                end
            end
            default: begin
                grant_a_s = 1'b0;
                grant_b_s = 1'b0;
            end
        endcase
    end

    // Ready is gated by reset so nothing looks accepted while held in reset.
    assign accept_a_s = grant_a_s & space_s & ~bus.FLUSH & RESET_N;
    assign accept_b_s = grant_b_s & space_s & ~bus.FLUSH & RESET_N;

    // One-hot decode of the destination held in the stage, for hazard checks.
    always_comb begin
        pending_s = {MASK_WIDTH{1'b0}};
        if (stage_valid_r) begin
            pending_s[stage_addr_r] = 1'b1;
        end else begin
            pending_s = {MASK_WIDTH{1'b0}};
        end
    end

    // Commit stage and round-robin history; flush wins over stall and accept.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            stage_valid_r <= 1'b0;
            stage_addr_r  <= {ADDR_WIDTH{1'b0}};
            stage_data_r  <= {DATA_WIDTH{1'b0}};
            last_grant_r  <= SRC_B;
        end else if (bus.FLUSH) begin
            stage_valid_r <= 1'b0;
        end else if (accept_a_s) begin
            stage_valid_r <= 1'b1;
            stage_addr_r  <= bus.A_ADDR;
            stage_data_r  <= bus.A_DATA;
            last_grant_r  <= SRC_A;
        end else if (accept_b_s) begin
            stage_valid_r <= 1'b1;
            stage_addr_r  <= bus.B_ADDR;
            stage_data_r  <= bus.B_DATA;
            last_grant_r  <= SRC_B;
        end else if (!bus.STALL) begin
            stage_valid_r <= 1'b0;
        end else begin
            stage_valid_r <= stage_valid_r;
        end
    end

    assign bus.A_READY = accept_a_s;
    assign bus.B_READY = accept_b_s;
    assign bus.WR_EN   = stage_valid_r & ~bus.STALL;
    assign bus.WR_ADDR = stage_addr_r;
    assign bus.WR_DATA = stage_data_r;
    assign bus.PENDING = pending_s;
endmodule
